// File: rtl/seq_gen_pkg.sv
// Shared types for the two-term recurrence generator: operation mode
// encodings and the sequencer state enum.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_XOR = 2'b10,
    MODE_AND = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    RUN    = 2'b10
  } state_t;

endpackage

// File: rtl/btn_edge.sv
// Button conditioner: multi-flop synchroniser followed by a rising-edge
// detector. Emits a single-cycle pulse per rising edge of the raw input,
// however long the input stays high.
module btn_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  // Fewer than two stages would not be a safe synchroniser.
  localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync;
  logic         edge_reg;

  // Shift the raw input through the synchroniser and remember the last output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= '0;
      edge_reg <= 1'b0;
    end else begin
      sync     <= {sync[N-2:0], din};
      edge_reg <= sync[N-1];
    end
  end

  assign pulse = sync[N-1] & ~edge_reg;

endmodule

// File: rtl/seq_gen.sv
// Parametrised two-term recurrence generator x(n+1) = x(n) OP x(n-1).
// Two seeds are loaded from din on successive en presses, then each press
// advances the sequence. Build option: define SEQ_GEN_SAT_EN to make ADD/SUB
// saturate instead of wrapping (ovf is set either way).
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             ready,
  output logic             ovf,
  output logic [CNT_W-1:0] step_cnt
);

  state_t           state;
  logic [WIDTH-1:0] a;       // x(n-1)
  logic [WIDTH-1:0] b;       // x(n)
  logic             pulse;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] result;
  logic             res_ovf;

  btn_edge #(
    .STAGES(SYNC_STAGES)
  ) u_en_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (en),
    .pulse(pulse)
  );

  // Next-term arithmetic; the extra MSB of each extended result is carry/borrow.
  always_comb begin
    sum_ext  = {1'b0, b} + {1'b0, a};
    diff_ext = {1'b0, b} - {1'b0, a};
    result   = '0;
    res_ovf  = 1'b0;
    case (mode_t'(mode))
      MODE_ADD: begin
        res_ovf = sum_ext[WIDTH];
`ifdef SEQ_GEN_SAT_EN
        result  = sum_ext[WIDTH] ? '1 : sum_ext[WIDTH-1:0];
`else
        result  = sum_ext[WIDTH-1:0];
`endif
      end
      MODE_SUB: begin
        res_ovf = diff_ext[WIDTH];
`ifdef SEQ_GEN_SAT_EN
        result  = diff_ext[WIDTH] ? '0 : diff_ext[WIDTH-1:0];
`else
        result  = diff_ext[WIDTH-1:0];
`endif
      end
      MODE_XOR: result = b ^ a;
      MODE_AND: result = b & a;
      default:  result = '0;
    endcase
  end

  // Sequencer: seed loading, stepping, sticky overflow and step counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD_A;
      a        <= '0;
      b        <= '0;
      ready    <= 1'b0;
      ovf      <= 1'b0;
      step_cnt <= '0;
    end else if (clr) begin
      state    <= LOAD_A;
      a        <= '0;
      b        <= '0;
      ready    <= 1'b0;
      ovf      <= 1'b0;
      step_cnt <= '0;
    end else if (pulse) begin
      case (state)
        LOAD_A: begin
          a     <= din;
          state <= LOAD_B;
        end
        LOAD_B: begin
          b     <= din;
          ready <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          a        <= b;
          b        <= result;
          ovf      <= ovf | res_ovf;
          step_cnt <= step_cnt + CNT_W'(1);
        end
        default: begin
          state <= LOAD_A;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign dout = b;

endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
- Parametrised two-term recurrence generator, the successor to the 8-bit switch/LED lab sequencer.
- Two seed values are loaded from `din` on successive `en` presses; each further press advances x(n+1) = x(n) OP x(n-1).
- Adds a width parameter, a runtime operation mode, an overflow flag and a step counter.
- Sits between the board switch/button inputs and the LED output.

Parameters:
WIDTH, 8, data path width of `din`, `dout` and internal terms
CNT_W, 4, width of the step counter
SYNC_STAGES, 2, synchroniser flops on `en` (minimum 2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  raw step/load button, asynchronous level, rising edge is the event
clr  in  1  synchronous clear back to seed loading, active-high
mode  in  2  operation: 00 ADD, 01 SUB, 10 XOR, 11 AND
din  in  WIDTH  seed value
dout  out  WIDTH  current term x(n)
ready  out  1  high in RUN state
ovf  out  1  sticky overflow/borrow flag
step_cnt  out  CNT_W  number of RUN steps taken

Behaviour:
- Reset (`rst_n`=0, asynchronous):
  - State goes to LOAD_A.
  - Internal a (x(n-1)) and b (x(n)) clear to 0.
  - `dout`=0, `ready`=0, `ovf`=0, `step_cnt`=0, synchroniser flops=0.
- Reset release takes effect at the next `clk` edge.
- `en` path:
  - SYNC_STAGES flops, then an edge register.
  - pulse = sync_out & ~edge_reg.
  - One pulse per `en` rising edge, however long `en` stays high.
  - Register update occurs at rising edge SYNC_STAGES+1 after `en` rises (3 edges at default).
- States:
  - LOAD_A: on pulse, a<=din; go to LOAD_B. `dout` unchanged.
  - LOAD_B: on pulse, b<=din, `dout`=din; go to RUN. `ready`=1 from that edge.
  - RUN: on pulse, a<=b; b<=result; `step_cnt`+=1, wrapping modulo 2^CNT_W.
- `dout` always equals b.
- Result, computed at WIDTH bits:
  - ADD = b+a; `ovf` sets if carry out.
  - SUB = b-a; `ovf` sets if borrow (b<a).
  - XOR = b^a. AND = b&a. Neither touches `ovf`.
- `mode` is sampled on the pulse cycle only. Changing it mid-sequence applies to the next step.
- `clr`=1 at an edge:
  - Return to LOAD_A; a, b, `ovf` and `step_cnt` go to 0.
  - `clr` has priority over a simultaneous pulse; that pulse is discarded.
- `ovf` is sticky until `clr` or reset.
- `din` is sampled only on a pulse in LOAD_A/LOAD_B.
- Asynchronous reset mid-RUN aborts immediately. No partial update survives.

Optional Feature:
- Macro SEQ_GEN_SAT_EN.
- When defined:
  - ADD saturates to 2^WIDTH-1 on carry.
  - SUB saturates to 0 on borrow.
  - `ovf` still sets.
- When undefined: results wrap modulo 2^WIDTH.
- Logical modes are identical in both builds.

Decomposition:
- Package seq_gen_pkg:
  - mode encodings MODE_ADD/SUB/XOR/AND.
  - state enum LOAD_A/LOAD_B/RUN.
- Sub-module btn_edge:
  - parametrised synchroniser plus rising-edge pulse.
  - Ports clk, rst_n, din, pulse; same reset polarity.
  - Reused for other button inputs.

Test Plan:
- Reset then seeds: WIDTH=8, ADD; press `en` with din=2, then din=3 -> `dout`=3, `ready`=1.
  - Three more presses -> `dout` 5, 8, 13; `step_cnt`=3; `ovf`=0.
- Held button: hold `en` high for 20 cycles in RUN -> exactly one step. Update lands 3 edges after the rise.
- Wrap, macro off: seeds 200, 100, ADD, one step -> `dout`=44, `ovf`=1.
  - Same with SEQ_GEN_SAT_EN -> `dout`=255, `ovf`=1.
- SUB and mode change: seeds 2, 3, SUB -> 1, then 254 with `ovf`=1.
  - Switch to XOR -> 1^254=255; `ovf` stays 1.
- `clr` with simultaneous pulse in RUN -> LOAD_A; `dout`=0, `step_cnt`=0, `ovf`=0; no step applied.
- `rst_n` low mid-RUN (asynchronous, between edges) -> all outputs 0 immediately; `ready`=0.
  - After release, the next press loads seed A.
